// File: rtl/nf_endian_pkg.sv
// Shared mode encodings and byte/keep permutation helpers for the AXI4-Stream endian bridge.
// Helpers work on a maximum-width container; callers pass the live byte count n.
package nf_endian_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_W32  = 2'd2;
  localparam logic [1:0] MODE_W16  = 2'd3;

  localparam int MAX_DW = 2048;
  localparam int MAX_N  = MAX_DW / 8;

  // Source byte lane feeding output lane i for an n-byte word.
  function automatic int src_byte(input int i, input int n, input logic [1:0] mode);
    int src;
    case (mode)
      MODE_FULL: src = n - 1 - i;
      MODE_W32:  src = (i & ~3) | (3 - (i & 3));
      MODE_W16:  src = i ^ 1;
      default:   src = i;
    endcase
    return src;
  endfunction

  function automatic logic [MAX_DW-1:0] swap_bytes(input logic [MAX_DW-1:0] data,
                                                   input logic [1:0] mode,
                                                   input int n);
    logic [MAX_DW-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        res[8*i +: 8] = data[8*src_byte(i, n, mode) +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_N-1:0] swap_keep(input logic [MAX_N-1:0] keep,
                                                 input logic [1:0] mode,
                                                 input int n);
    logic [MAX_N-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        res[i] = keep[src_byte(i, n, mode)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nf_axis_skid_slice.sv
// Two-entry registered slice: an output register plus one skid entry behind it.
// Valid/ready: a transfer happens on any cycle where valid && ready; s_ready is a flop output.
module nf_axis_skid_slice #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [PW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  logic [PW-1:0] out_data;
  logic [PW-1:0] skid_data;
  logic          out_valid;
  logic          skid_valid;
  logic          s_fire;
  logic          out_free;

  // Ready depends only on the skid flop, so it never combinationally follows m_ready.
  assign s_ready  = ~skid_valid;
  assign s_fire   = s_valid && ~skid_valid;
  assign out_free = ~out_valid || m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= s_fire;
        if (s_fire) begin
          out_data <= s_data;
        end
      end
    end else if (s_fire) begin
      // Output is stalled: park the incoming beat and drop ready next cycle.
      skid_data  <= s_data;
      skid_valid <= 1'b1;
    end
  end

  assign m_data  = out_data;
  assign m_valid = out_valid;

endmodule

// File: rtl/nf_axis_endian_swap_bridge.sv
// AXI4-Stream byte-order converter with a per-packet latched swap mode and packet statistics.
// The permutation is combinational ahead of a two-entry register slice; one beat per cycle.
module nf_axis_endian_swap_bridge
  import nf_endian_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEFAULT_MODE     = 1,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      cfg_mode,
  input  logic                            cfg_mode_wr,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [C_CNT_WIDTH-1:0]          stat_pkt_count,
  output logic                            stat_in_pkt
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int CW = C_CNT_WIDTH;
  localparam int N  = DW / 8;
  localparam int PW = DW + N + UW + 1;
  localparam logic [1:0] DEFAULT_MODE = 2'(C_DEFAULT_MODE);

  logic [1:0]        pending_mode;
  logic [1:0]        active_mode;
  logic [1:0]        beat_mode;
  logic              in_pkt;
  logic [CW-1:0]     pkt_count;
  logic              s_ready;
  logic              s_fire;

  logic [MAX_DW-1:0] data_ext;
  logic [MAX_N-1:0]  keep_ext;
  logic [MAX_DW-1:0] data_sw_ext;
  logic [MAX_N-1:0]  keep_sw_ext;
  logic              unused_sw;

  logic [PW-1:0]     slice_in;
  logic [PW-1:0]     slice_out;
  logic              slice_valid;

  assign s_fire = s_axis_tvalid && s_ready;

  // A first beat uses the pending mode directly; later beats use the mode latched with it.
  assign beat_mode = in_pkt ? active_mode : pending_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mode <= DEFAULT_MODE;
      active_mode  <= DEFAULT_MODE;
      in_pkt       <= 1'b0;
      pkt_count    <= '0;
    end else begin
      if (cfg_mode_wr) begin
        pending_mode <= cfg_mode;
      end
      if (s_fire) begin
        if (!in_pkt) begin
          active_mode <= pending_mode;
        end
        in_pkt <= ~s_axis_tlast;
        if (s_axis_tlast) begin
          pkt_count <= pkt_count + CW'(1);
        end
      end
    end
  end

  always_comb begin
    data_ext           = '0;
    keep_ext           = '0;
    data_ext[DW-1:0]   = s_axis_tdata;
    keep_ext[N-1:0]    = s_axis_tkeep;
    data_sw_ext        = swap_bytes(data_ext, beat_mode, N);
    keep_sw_ext        = swap_keep(keep_ext, beat_mode, N);
  end

  // Lanes above the configured width are always zero and intentionally discarded.
  assign unused_sw = ^{data_sw_ext, keep_sw_ext};

  assign slice_in = {data_sw_ext[DW-1:0], keep_sw_ext[N-1:0], s_axis_tuser, s_axis_tlast};

  nf_axis_skid_slice #(
    .PW (PW)
  ) u_slice (
    .clk     (clk),
    .reset   (reset),
    .s_data  (slice_in),
    .s_valid (s_axis_tvalid),
    .s_ready (s_ready),
    .m_data  (slice_out),
    .m_valid (slice_valid),
    .m_ready (m_axis_tready)
  );

  assign s_axis_tready  = s_ready;
  assign m_axis_tvalid  = slice_valid;
  assign m_axis_tdata   = slice_out[PW-1 -: DW];
  assign m_axis_tkeep   = slice_out[UW+1 +: N];
  assign m_axis_tuser   = slice_out[1 +: UW];
  assign m_axis_tlast   = slice_out[0];
  assign stat_pkt_count = pkt_count;
  assign stat_in_pkt    = in_pkt;

endmodule

// File: tb/tb_nf_axis_endian_swap_bridge.sv
// Self-checking bench for nf_axis_endian_swap_bridge: directed literal cases plus randomized
// traffic scored against a byte-level reference model of the swap, mode latch and statistics.
module tb_nf_axis_endian_swap_bridge;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 16;
  localparam int CW = 4;
  localparam int W  = DW + KW + UW + 1;
  localparam logic [1:0] DEF_MODE = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_mode_wr = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [CW-1:0] stat_pkt_count;
  logic          stat_in_pkt;

  nf_axis_endian_swap_bridge #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .C_DEFAULT_MODE     (1),
    .C_CNT_WIDTH        (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_mode       (cfg_mode),
    .cfg_mode_wr    (cfg_mode_wr),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .stat_pkt_count (stat_pkt_count),
    .stat_in_pkt    (stat_in_pkt)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_src(input int i, input int m);
    case (m)
      1:       return KW - 1 - i;
      2:       return 4 * (i / 4) + 3 - (i % 4);
      3:       return 2 * (i / 2) + 1 - (i % 2);
      default: return i;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d, input int m);
    logic [7:0]    b [KW];
    logic [DW-1:0] r;
    for (int i = 0; i < KW; i++) b[i] = d[8*i +: 8];
    r = '0;
    for (int i = 0; i < KW; i++) r[8*i +: 8] = b[ref_src(i, m)];
    return r;
  endfunction

  function automatic logic [KW-1:0] ref_keep(input logic [KW-1:0] k, input int m);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < KW; i++) r[i] = k[ref_src(i, m)];
    return r;
  endfunction

  logic [W-1:0]  exp_q[$];
  logic [1:0]    mdl_pending = DEF_MODE;
  logic [1:0]    mdl_active  = DEF_MODE;
  logic          mdl_in_pkt  = 1'b0;
  logic [CW-1:0] mdl_count   = '0;
  logic          prev_stall  = 1'b0;
  logic [W-1:0]  prev_out    = '0;
  int            m_fires     = 0;

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [1:0]   bm;
    logic [W-1:0] got;
    got = {m_tdata, m_tkeep, m_tuser, m_tlast};
    if (reset) begin
      exp_q.delete();
      mdl_pending = DEF_MODE;
      mdl_active  = DEF_MODE;
      mdl_in_pkt  = 1'b0;
      mdl_count   = '0;
      prev_stall  = 1'b0;
    end else begin
      chk("stat_pkt_count", 128'(stat_pkt_count), 128'(mdl_count));
      chk("stat_in_pkt", 128'(stat_in_pkt), 128'(mdl_in_pkt));
      chk("m_tvalid_occupancy", 128'(m_tvalid), 128'(exp_q.size() > 0));
      chk("s_tready_occupancy", 128'(s_tready), 128'(exp_q.size() < 2));
      if (prev_stall) chk("stall_hold", 128'(got), 128'(prev_out));
      if (m_tvalid && m_tready) begin
        m_fires++;
        if (exp_q.size() == 0) chk("unexpected_beat", 128'(got), 128'(0));
        else chk("m_beat", 128'(got), 128'(exp_q.pop_front()));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = got;
      if (s_tvalid && s_tready) begin
        bm = mdl_in_pkt ? mdl_active : mdl_pending;
        if (!mdl_in_pkt) mdl_active = mdl_pending;
        exp_q.push_back({ref_data(s_tdata, int'(bm)), ref_keep(s_tkeep, int'(bm)), s_tuser, s_tlast});
        mdl_in_pkt = !s_tlast;
        if (s_tlast) mdl_count = mdl_count + 1'b1;
      end
      if (cfg_mode_wr) mdl_pending = cfg_mode;
    end
  end

  // ---------------- random m_tready ----------------
  logic rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; s_tvalid = 1'b0; cfg_mode_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                           input logic l, input logic wr, input logic [1:0] wm, output int waited);
    @(posedge clk); #1;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    cfg_mode_wr = wr; cfg_mode = wm;
    waited = 0;
    @(negedge clk);
    while (!s_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("send_timeout", 128'(s_tready), 128'(1));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_tvalid = 1'b0; cfg_mode_wr = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] m);
    @(posedge clk); #1;
    cfg_mode = m; cfg_mode_wr = 1'b1;
    @(posedge clk); #1;
    cfg_mode_wr = 1'b0;
  endtask

  // Sends one beat with m_tready=1 and checks the literal output one cycle later.
  task automatic send_chk(input string name, input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic l, input logic wr, input logic [1:0] wm,
                          input logic [DW-1:0] ed, input logic [KW-1:0] ek);
    int w;
    send_beat(d, k, 16'h5AA5, l, wr, wm, w);
    idle();
    @(negedge clk);
    chk({name, "_valid"}, 128'(m_tvalid), 128'(1));
    chk({name, "_data"}, 128'(m_tdata), 128'(ed));
    chk({name, "_keep"}, 128'(m_tkeep), 128'(ek));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, stalls, fires0, len, t;
    logic [KW-1:0] k;

    do_reset();
    @(negedge clk);
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_fields", 128'({m_tdata, m_tkeep, m_tuser, m_tlast}), 128'(0));
    chk("rst_s_tready", 128'(s_tready), 128'(1));
    chk("rst_count", 128'(stat_pkt_count), 128'(0));
    chk("rst_in_pkt", 128'(stat_in_pkt), 128'(0));

    // Default mode is full reverse.
    send_chk("t1_full", 64'h0807060504030201, 8'h0F, 1'b1, 1'b0, 2'd0, 64'h0102030405060708, 8'hF0);
    cfg_write(2'd2);
    send_chk("t2_w32", 64'h0807060504030201, 8'h0F, 1'b1, 1'b0, 2'd0, 64'h0506070801020304, 8'h0F);
    cfg_write(2'd3);
    send_chk("t2_w16", 64'h0807060504030201, 8'h0F, 1'b1, 1'b0, 2'd0, 64'h0708050603040102, 8'h0F);
    send_chk("t2_w16_keep", 64'h0807060504030201, 8'h12, 1'b1, 1'b0, 2'd0, 64'h0708050603040102, 8'h21);
    send_chk("zero_keep", 64'h0807060504030201, 8'h00, 1'b1, 1'b0, 2'd0, 64'h0708050603040102, 8'h00);

    // Mid-packet cfg write only affects the following packet.
    cfg_write(2'd1);
    send_chk("t3_b1", 64'h1122334455667788, 8'h03, 1'b0, 1'b0, 2'd0, 64'h8877665544332211, 8'hC0);
    chk("t3_in_pkt_mid", 128'(stat_in_pkt), 128'(1));
    send_chk("t3_b2", 64'h1122334455667788, 8'hFF, 1'b0, 1'b1, 2'd0, 64'h8877665544332211, 8'hFF);
    send_chk("t3_b3", 64'hA0B0C0D0E0F00102, 8'h01, 1'b1, 1'b0, 2'd0, 64'h0201F0E0D0C0B0A0, 8'h80);
    chk("t3_in_pkt_end", 128'(stat_in_pkt), 128'(0));
    send_chk("t3_next_pass", 64'hDEADBEEF01234567, 8'h3C, 1'b1, 1'b0, 2'd0, 64'hDEADBEEF01234567, 8'h3C);

    // Full rate: five 4-beat packets back to back.
    do_reset();
    m_tready = 1'b1;
    stalls = 0;
    fires0 = m_fires;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 4; b++) begin
        send_beat({$urandom, $urandom}, 8'($urandom_range(0, 255)), 16'($urandom), b == 3, 1'b0, 2'd0, w);
        stalls += w;
      end
    end
    idle();
    repeat (3) @(negedge clk);
    chk("t5_stalls", 128'(stalls), 128'(0));
    chk("t5_count", 128'(stat_pkt_count), 128'(5));
    chk("t5_in_pkt", 128'(stat_in_pkt), 128'(0));
    chk("t5_out_beats", 128'(m_fires - fires0), 128'(20));

    // Random backpressure, continuous valid, random packets and mode writes.
    rnd_ready = 1'b1;
    t = 0;
    while (t < 1000) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        k = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        send_beat({$urandom, $urandom}, k, 16'($urandom), b == len - 1,
                  $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), w);
        t++;
      end
    end
    idle();
    @(posedge clk); #1;
    rnd_ready = 1'b0;
    m_tready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t4_drain", 128'(exp_q.size()), 128'(0));

    // Reset with the skid full in the middle of a packet.
    m_tready = 1'b0;
    send_beat(64'h1111111111111111, 8'hFF, 16'h1, 1'b0, 1'b0, 2'd0, w);
    send_beat(64'h2222222222222222, 8'hFF, 16'h2, 1'b0, 1'b0, 2'd0, w);
    idle();
    @(negedge clk);
    chk("t6_skid_full_ready", 128'(s_tready), 128'(0));
    chk("t6_pre_valid", 128'(m_tvalid), 128'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_valid", 128'(m_tvalid), 128'(0));
    chk("t6_count", 128'(stat_pkt_count), 128'(0));
    chk("t6_in_pkt", 128'(stat_in_pkt), 128'(0));
    chk("t6_ready", 128'(s_tready), 128'(1));
    m_tready = 1'b1;
    fires0 = m_fires;
    repeat (5) @(negedge clk);
    chk("t6_no_stale", 128'(m_fires - fires0), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
